instruction_fetch: RTL and testbench

//   Fetch stage directly upstream of InstructionMemory. Owns the program counter.

---
 rtl/instruction_fetch_pkg.sv | 14 +
 rtl/fetch_skid_fifo.sv | 55 +++++
 rtl/instruction_fetch.sv | 85 ++++++++
 tb/tb_instruction_fetch.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants and the {pc, instr} entry type handed to decode.
package instruction_fetch_pkg;

  localparam int unsigned ADDR_WIDTH  = 64;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned PC_STEP     = 4;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO between fetch and decode; flush empties it without clearing storage.
module fetch_skid_fifo #(
  parameter int unsigned WIDTH = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q;
  logic             push_eff, pop_eff;

  assign valid    = (count_q != 2'd0);
  assign full     = (count_q == 2'd2);
  assign rdata    = mem_q[rd_ptr_q];
  assign pop_eff  = pop & valid;
  // A full FIFO accepts a write only when the head leaves in the same cycle.
  assign push_eff = push & (!full | pop_eff);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_eff) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_eff) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives InstructionMemory, buffers {pc, instr} for decode,
// and handles redirects, halt and misaligned-target faults.
module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH  = instruction_fetch_pkg::ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = instruction_fetch_pkg::INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = instruction_fetch_pkg::RESET_PC,
  parameter int unsigned PC_STEP     = instruction_fetch_pkg::PC_STEP
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  input  logic [63:0]            instr_in,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic                   fault,
  output logic [ADDR_WIDTH-1:0]  fault_addr
);

  import instruction_fetch_pkg::*;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q, fault_addr_q;
  logic                  fault_q;
  logic                  pop, push, misaligned, fifo_full;
  entry_t                wr_entry, head;
  logic                  unused_instr_hi;

  assign unused_instr_hi = ^instr_in[63:INSTR_WIDTH];

  assign pc_out     = pc_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
  assign out_pc     = head.pc;
  assign out_instr  = head.instr;

  assign misaligned = |redirect_target[1:0];
  assign pop        = out_valid & out_ready;
  assign push       = !halt & !fault_q & !redirect_valid & (!fifo_full | pop);
  assign wr_entry   = '{pc: pc_q, instr: instr_in[INSTR_WIDTH-1:0]};

  // Redirect flushes the buffer, discarding any pop in the same cycle.
  fetch_skid_fifo #(
    .WIDTH($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .valid (out_valid),
    .full  (fifo_full),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else if (redirect_valid) begin
      if (misaligned) begin
        fault_q <= 1'b1;
        // Keep the first offending target if faults repeat.
        if (!fault_q) begin
          fault_addr_q <= redirect_target;
        end
      end else begin
        pc_q <= redirect_target;
      end
    end else if (push) begin
      pc_q <= pc_q + ADDR_WIDTH'(PC_STEP);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch against an identity-pattern memory model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_out;
  logic [63:0] instr_in;
  logic        halt;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
  logic [63:0] fault_addr;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #10 clk = ~clk;

  // Byte at address a holds a[7:0].
  function automatic logic [63:0] mem_word(input logic [63:0] addr);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = addr[7:0] + 8'(i);
    return w;
  endfunction

  assign #10 instr_in = mem_word(pc_out);

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .pc_out          (pc_out),
    .instr_in        (instr_in),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr),
    .fault           (fault),
    .fault_addr      (fault_addr)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_target = '0; out_ready = 1'b0;

    // 1: reset, then stream with out_ready=1
    cyc(); cyc(); cyc();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc_out", pc_out, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_fault_addr", fault_addr, 64'd0);
    reset = 1'b0; out_ready = 1'b1;
    cyc();
    chk("t1_valid0", 64'(out_valid), 64'd1);
    chk("t1_pc0", out_pc, 64'd0);
    chk("t1_instr0", 64'(out_instr), 64'h03020100);
    cyc();
    chk("t1_pc4", out_pc, 64'd4);
    chk("t1_instr4", 64'(out_instr), 64'h07060504);
    cyc();
    chk("t1_pc8", out_pc, 64'd8);
    chk("t1_instr8", 64'(out_instr), 64'h0b0a0908);
    cyc();
    chk("t1_pc12", out_pc, 64'd12);
    chk("t1_instr12", 64'(out_instr), 64'h0f0e0d0c);

    // 2: back-pressure saturates at two entries
    reset = 1'b1; out_ready = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("t2_pc_out_stall", pc_out, 64'd8);
    chk("t2_head_stall", out_pc, 64'd0);
    chk("t2_valid_stall", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    cyc();
    chk("t2_pc4", out_pc, 64'd4);
    chk("t2_pc_out12", pc_out, 64'd12);
    cyc();
    chk("t2_pc8", out_pc, 64'd8);
    chk("t2_instr8", 64'(out_instr), 64'h0b0a0908);

    // 3: redirect while full
    redirect_valid = 1'b1; redirect_target = 64'h40;
    cyc();
    redirect_valid = 1'b0;
    chk("t3_valid_flushed", 64'(out_valid), 64'd0);
    chk("t3_pc_out", pc_out, 64'h40);
    cyc();
    chk("t3_out_pc", out_pc, 64'h40);
    chk("t3_out_instr", 64'(out_instr), 64'h43424140);

    // 4: misaligned redirect faults; reset clears it
    redirect_valid = 1'b1; redirect_target = 64'h42;
    cyc();
    redirect_valid = 1'b0;
    chk("t4_fault", 64'(fault), 64'd1);
    chk("t4_fault_addr", fault_addr, 64'h42);
    chk("t4_valid", 64'(out_valid), 64'd0);
    chk("t4_pc_out", pc_out, 64'h44);
    cyc(); cyc();
    chk("t4_valid_hold", 64'(out_valid), 64'd0);
    chk("t4_pc_out_hold", pc_out, 64'h44);
    reset = 1'b1; out_ready = 1'b0;
    cyc();
    chk("t4_fault_clr", 64'(fault), 64'd0);
    chk("t4_fault_addr_clr", fault_addr, 64'd0);
    chk("t4_pc_out_rst", pc_out, 64'd0);

    // 5: halt drains the buffer and freezes the PC
    reset = 1'b0;
    cyc(); cyc();
    chk("t5_pc_out_full", pc_out, 64'd8);
    halt = 1'b1; out_ready = 1'b1;
    cyc();
    chk("t5_drain1_valid", 64'(out_valid), 64'd1);
    chk("t5_drain1_pc", out_pc, 64'd4);
    cyc();
    chk("t5_empty", 64'(out_valid), 64'd0);
    cyc();
    chk("t5_empty_hold", 64'(out_valid), 64'd0);
    chk("t5_pc_out_hold", pc_out, 64'd8);
    halt = 1'b0;
    cyc();
    chk("t5_resume_pc", out_pc, 64'd8);
    chk("t5_resume_valid", 64'(out_valid), 64'd1);

    // 6: PC wraps at the top of the address space
    redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    chk("t6_pc_out", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc();
    chk("t6_top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_top_instr", 64'(out_instr), 64'hFFFEFDFC);
    chk("t6_pc_out_wrap", pc_out, 64'd0);
    cyc();
    chk("t6_wrap_pc", out_pc, 64'd0);
    chk("t6_wrap_instr", 64'(out_instr), 64'h03020100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
